// File: rtl/address_gen_pkg.sv
// Shared definitions for the address generator: FSM state encoding.
package address_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/address_gen_loop_counter.sv
// Inner/outer loop counter pair; advances on en and flags the last inner
// step and the last step of the whole sequence.
module addr_loop_counter
    import address_gen_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                en,
    input  logic [PERIOD_W-1:0] per,
    input  logic [PERIOD_W-1:0] iter,
    output logic                last_inner,
    output logic                last_all
);

    logic [PERIOD_W-1:0] inner;
    logic [PERIOD_W-1:0] outer;

    assign last_inner = (inner == per - PERIOD_W'(1));
    assign last_all   = last_inner && (outer == iter - PERIOD_W'(1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            inner <= '0;
            outer <= '0;
        end else if (en) begin
            if (last_inner) begin
                inner <= '0;
                outer <= outer + PERIOD_W'(1);
            end else begin
                inner <= inner + PERIOD_W'(1);
            end
        end
    end

endmodule

// File: rtl/address_gen.sv
// Two-level strided address generator with valid/ready output handshake.
// Optional start delay enabled by defining ADDRESS_GEN_DELAY_EN.
module address_gen
    import address_gen_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   incr,
    input  logic [ADDR_W-1:0]   shift,
    input  logic [PERIOD_W-1:0] per,
    input  logic [PERIOD_W-1:0] iter,
    input  logic [PERIOD_W-1:0] delay,
    output logic                gen_valid,
    input  logic                gen_ready,
    output logic [ADDR_W-1:0]   gen_addr,
    output logic                busy,
    output logic                done
);

    state_t              state, state_next;
    logic [ADDR_W-1:0]   incr_q, shift_q, line_base, addr_q;
    logic [PERIOD_W-1:0] per_q, iter_q;
    logic                valid_q, done_q, done_next;
    logic                load, hs, empty, last_inner, last_all;

`ifdef ADDRESS_GEN_DELAY_EN
    logic [PERIOD_W-1:0] dcnt;
`else
    logic                unused_delay;
    assign unused_delay = ^delay;
`endif

    assign hs    = valid_q & gen_ready;
    assign empty = (per == '0) || (iter == '0);

    addr_loop_counter #(.PERIOD_W(PERIOD_W)) u_loop (
        .clk        (clk),
        .rst        (rst),
        .clear      (load),
        .en         (hs),
        .per        (per_q),
        .iter       (iter_q),
        .last_inner (last_inner),
        .last_all   (last_all)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    if (empty) begin
                        done_next = 1'b1;
                    end else begin
                        load = 1'b1;
`ifdef ADDRESS_GEN_DELAY_EN
                        state_next = (delay != '0) ? ST_DELAY : ST_RUN;
`else
                        state_next = ST_RUN;
`endif
                    end
                end
            end
`ifdef ADDRESS_GEN_DELAY_EN
            ST_DELAY: begin
                if (dcnt == '0) state_next = ST_RUN;
            end
`endif
            ST_RUN: begin
                if (hs && last_all) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // gen_valid is registered from the next state so it tracks RUN exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            incr_q    <= '0;
            shift_q   <= '0;
            per_q     <= '0;
            iter_q    <= '0;
            line_base <= '0;
            addr_q    <= '0;
`ifdef ADDRESS_GEN_DELAY_EN
            dcnt      <= '0;
`endif
        end else begin
            valid_q <= (state_next == ST_RUN);
            done_q  <= done_next;
            if (load) begin
                incr_q    <= incr;
                shift_q   <= shift;
                per_q     <= per;
                iter_q    <= iter;
                line_base <= start_addr;
                addr_q    <= start_addr;
`ifdef ADDRESS_GEN_DELAY_EN
                dcnt      <= delay - PERIOD_W'(1);
`endif
            end else if (hs) begin
                if (last_inner) begin
                    line_base <= line_base + shift_q;
                    addr_q    <= line_base + shift_q;
                end else begin
                    addr_q    <= addr_q + incr_q;
                end
            end
`ifdef ADDRESS_GEN_DELAY_EN
            else if (state == ST_DELAY) begin
                dcnt <= dcnt - PERIOD_W'(1);
            end
`endif
        end
    end

    assign gen_valid = valid_q;
    assign gen_addr  = addr_q;
    assign done      = done_q;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_address_gen.sv
// Randomized self-checking bench for address_gen against a nested-loop
// address list model.
module tb_address_gen;

    localparam int ADDR_W   = 32;
    localparam int PERIOD_W = 16;

`ifdef ADDRESS_GEN_DELAY_EN
    localparam bit DELAY_EN = 1'b1;
`else
    localparam bit DELAY_EN = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic                run;
    logic [ADDR_W-1:0]   start_addr, incr, shift;
    logic [PERIOD_W-1:0] per, iter, delay;
    logic                gen_valid, gen_ready, busy, done;
    logic [ADDR_W-1:0]   gen_addr;

    int n_checks = 0;
    int n_pass   = 0;

    address_gen #(.ADDR_W(ADDR_W), .PERIOD_W(PERIOD_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .start_addr (start_addr),
        .incr       (incr),
        .shift      (shift),
        .per        (per),
        .iter       (iter),
        .delay      (delay),
        .gen_valid  (gen_valid),
        .gen_ready  (gen_ready),
        .gen_addr   (gen_addr),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 = ready always high, 1 = ready toggles 1,0,..., 2 = random ready
    // rst_after: nonzero -> reset after that many handshakes
    task automatic run_seq(input logic [31:0] s, input logic [31:0] inc, input logic [31:0] sh,
                           input int p, input int it, input int d, input int mode,
                           input int rst_after);
        logic [31:0] exp_q[$];
        logic [31:0] a;
        int idx, cyc, stall, eff_delay;
        bit rdy;

        for (int o = 0; o < it; o++)
            for (int k = 0; k < p; k++) begin
                a = s + sh * 32'(o) + inc * 32'(k);
                exp_q.push_back(a);
            end

        start_addr = s; incr = inc; shift = sh;
        per = 16'(p); iter = 16'(it); delay = 16'(d);
        gen_ready = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        start_addr = $urandom; incr = $urandom; shift = $urandom;
        per = 16'($urandom); iter = 16'($urandom); delay = 16'($urandom);

        if (exp_q.size() == 0) begin
            check("empty_done", done, 1);
            check("empty_valid", gen_valid, 0);
            check("empty_busy", busy, 0);
            tick();
            check("empty_done_clr", done, 0);
            check("empty_valid2", gen_valid, 0);
            return;
        end

        eff_delay = DELAY_EN ? d : 0;
        for (int c = 0; c < eff_delay; c++) begin
            check("delay_valid", gen_valid, 0);
            check("delay_busy", busy, 1);
            check("delay_done", done, 0);
            if (c == 1) begin
                run = 1'b1; per = 16'd1; iter = 16'd1; start_addr = $urandom;
            end
            tick();
            run = 1'b0;
        end

        idx = 0; cyc = 0; stall = 0;
        while (idx < exp_q.size()) begin
            check("run_valid", gen_valid, 1);
            check("run_addr", gen_addr, exp_q[idx]);
            check("run_done", done, 0);
            check("run_busy", busy, 1);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = (stall >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            if (cyc == 1 && exp_q.size() > 2) begin
                run = 1'b1; per = 16'd1; iter = 16'd1; start_addr = $urandom;
            end
            gen_ready = rdy;
            tick();
            run = 1'b0;
            cyc++;
            if (rdy) begin idx++; stall = 0; end
            else stall++;
            if (rst_after != 0 && idx == rst_after) begin
                gen_ready = 1'b0;
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check("rst_valid", gen_valid, 0);
                check("rst_done", done, 0);
                check("rst_busy", busy, 0);
                check("rst_addr", gen_addr, 0);
                tick();
                check("rst_done2", done, 0);
                check("rst_valid2", gen_valid, 0);
                return;
            end
        end
        gen_ready = 1'b0;
        check("end_valid", gen_valid, 0);
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        tick();
        check("end_done_clr", done, 0);
        check("end_valid2", gen_valid, 0);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; gen_ready = 1'b0;
        start_addr = '0; incr = '0; shift = '0;
        per = '0; iter = '0; delay = '0;
        tick();
        tick();
        check("reset_valid", gen_valid, 0);
        check("reset_addr", gen_addr, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b0;
        tick();

        run_seq(32'h100, 32'd4, 32'h40, 3, 2, 0, 0, 0);
        run_seq(32'h100, 32'd4, 32'h40, 3, 2, 0, 1, 0);
        run_seq(32'h100, 32'd4, 32'h40, 0, 5, 0, 0, 0);
        run_seq(32'hFFFF_FFFC, 32'd4, 32'h0, 2, 1, 0, 0, 0);
        run_seq(32'h100, 32'd4, 32'h40, 3, 2, 0, 0, 2);
        run_seq(32'h100, 32'd4, 32'h40, 3, 2, 0, 0, 0);
        run_seq(32'h100, 32'd4, 32'h40, 3, 2, 3, 0, 0);

        for (int n = 0; n < 40; n++) begin
            run_seq($urandom, $urandom, $urandom,
                    $urandom_range(0, 4), $urandom_range(0, 3),
                    $urandom_range(0, 4), 2, 0);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
